iterative_muldiv_hilo: RTL
==========================

# iterative_muldiv_hilo

Sequential multiply/divide unit that owns the architectural HI/LO registers. The EX stage issues MULT/MULTU/DIV/DIVU to it with a start pulse. It computes the result with a 32-step shift-add/restoring-divide engine, then writes HI/LO. While it works it reports busy, so the hazard unit stalls MFHI/MFLO/MTHI/MTLO and new mult/div issues.

## Interface
- Parameters: none; operand and result width is fixed at 32 bits.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue request; sampled only when busy=0.
- op  in  2  00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div.
- a  in  32  operand A (multiplicand / dividend); captured on accepted start.
- b  in  32  operand B (multiplier / divisor); captured on accepted start.
- cancel  in  1  pipeline flush; aborts an in-flight operation.
- mthi  in  1  write wdata to HI (MTHI).
- mtlo  in  1  write wdata to LO (MTLO).
- wdata  in  32  data for mthi/mtlo.
- busy  out  1  operation in flight (RUN or FIX state).
- done  out  1  one-cycle pulse: HI/LO just updated by a completed operation.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1: the unit latches op, a and b, clears the step counter and goes to RUN.
  - Signed ops latch |a| and |b|, and record sign_q = a[31]^b[31] and sign_r = a[31].
- RUN: one iteration per cycle; counter 0..31; after the iteration with counter=31 the unit goes to FIX.
  - Multiply: 64-bit accumulator. If multiplier LSB=1, add the multiplicand to the upper half. Shift right 1 (unsigned, with carry-in).
  - Divide: restoring. Shift {rem,quot} left 1. If rem ≥ divisor, subtract and set the quotient bit.
- FIX: applies the sign and writes HI/LO, then goes to IDLE.
  - Signed mult: the 64-bit product is negated if sign_q=1.
  - Signed div: the quotient is negated if sign_q=1; the remainder is negated if sign_r=1. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Mult writes {hi,lo}=product. Div writes lo=quotient, hi=remainder.
- Divide by zero (b=0, either op): full latency, lo=32'hFFFFFFFF, hi=a (the original, unmodified operand).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo: honoured only in IDLE with start=0. HI/LO is written on the next edge; both may be asserted together.
  - mthi/mtlo are ignored while busy; the hazard unit must stall them.
  - If start and mthi/mtlo arrive in the same cycle, start wins and the mt writes are dropped.
- start while busy is ignored; no queuing.
- cancel in RUN or FIX: next edge goes to IDLE. HI/LO are unchanged and done stays 0. cancel in IDLE has no effect.
- cancel and start in the same IDLE cycle: start is not accepted.

## Timing
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Start accepted at edge k:
  - busy=1 from after edge k through edge k+33, i.e. 33 cycles: 32 RUN + 1 FIX.
  - Edge k+33 updates hi/lo, sets done=1, busy=0.
  - Latency is 33 cycles from the accepting edge to valid HI/LO, identical for all ops and operand values.
- done is high exactly one cycle, then returns to 0. It is never asserted for mthi/mtlo or for a cancelled operation.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted at that edge.
- rst mid-operation: at the next edge all state returns to reset values, including hi/lo=0. The partial result is discarded.
- hi/lo outputs are registers and change only on a FIX completion, an mthi/mtlo write, or rst.

## Test plan
- Signed mult: a=7, b=0xFFFFFFFD, op=00 → after 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy high for exactly 33 cycles.
- Unsigned mult: a=b=0xFFFFFFFF, op=01 → hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start in the done cycle: a=3, b=5, op=01 → hi=0, lo=15 after 33 more cycles.
- Division: a=0xFFFFFFF9 (−7), b=2, op=10 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then a=100, b=7, op=11 → lo=14, hi=2.
- Boundaries:
  - a=5, b=0, op=11 → lo=0xFFFFFFFF, hi=5.
  - a=0x80000000, b=0xFFFFFFFF, op=10 → lo=0x80000000, hi=0.
- mthi/mtlo:
  - In IDLE, mthi with wdata=0x1234 → hi=0x1234 next cycle.
  - mtlo asserted while busy → lo unchanged.
  - start+mtlo in the same cycle → operation runs, mt write dropped.
- Abort:
  - cancel at cycle 10 of a mult → busy=0 next cycle, hi/lo hold their prior values, no done.
  - rst at cycle 20 of a div → hi=lo=0, busy=0, done=0.
  - A start issued while busy → ignored; the original result completes unaffected.

Source files
------------

// File: rtl/iterative_muldiv_hilo.sv
// iterative_muldiv_hilo: 32-step shift-add multiplier / restoring divider owning HI/LO
module iterative_muldiv_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [63:0] r_acc;
  logic [31:0] r_m, r_a, r_hi, r_lo;
  logic        r_sq, r_sr, r_done;
  logic        w_accept, w_ge, w_dz, w_signed;
  logic [31:0] w_abs_a, w_abs_b, w_rnew, w_q, w_r, w_hi_fix, w_lo_fix;
  logic [32:0] w_madd, w_rsh, w_rsub;
  logic [63:0] w_mstep, w_dstep, w_prod;
  assign w_accept = (r_state == IDLE) && start && !cancel;
  assign w_abs_a  = (!op[0] && a[31]) ? -a : a;
  assign w_abs_b  = (!op[0] && b[31]) ? -b : b;
  // multiply: r_acc = {partial product, remaining multiplier}, r_m = multiplicand
  assign w_madd   = {1'b0, r_acc[63:32]} + {1'b0, r_m};
  assign w_mstep  = r_acc[0] ? {w_madd, r_acc[31:1]} : {1'b0, r_acc[63:1]};
  // divide: r_acc = {remainder, dividend/quotient}, r_m = divisor
  assign w_rsh    = r_acc[63:31];
  assign w_rsub   = w_rsh - {1'b0, r_m};
  assign w_ge     = w_rsh >= {1'b0, r_m};
  assign w_rnew   = w_ge ? w_rsub[31:0] : w_rsh[31:0];
  assign w_dstep  = {w_rnew, r_acc[30:0], w_ge};
  assign w_signed = !r_op[0];
  assign w_prod   = (w_signed && r_sq) ? -r_acc : r_acc;
  assign w_q      = (w_signed && r_sq) ? -r_acc[31:0] : r_acc[31:0];
  assign w_r      = (w_signed && r_sr) ? -r_acc[63:32] : r_acc[63:32];
  assign w_dz     = r_m == 32'd0;
  assign w_hi_fix = !r_op[1] ? w_prod[63:32] : w_dz ? r_a : w_r;
  assign w_lo_fix = !r_op[1] ? w_prod[31:0] : w_dz ? 32'hFFFF_FFFF : w_q;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_accept ? RUN : IDLE) :
             cancel ? IDLE :
             (r_state == RUN) ? ((r_cnt == 5'd31) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == FIX) && !cancel;
      if (w_accept) begin
        r_op  <= op;
        r_cnt <= '0;
        r_m   <= op[1] ? w_abs_b : w_abs_a;
        r_acc <= {32'd0, op[1] ? w_abs_a : w_abs_b};
        r_a   <= a;
        r_sq  <= a[31] ^ b[31];
        r_sr  <= a[31];
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= r_op[1] ? w_dstep : w_mstep;
      end
      if ((r_state == FIX) && !cancel) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end else if ((r_state == IDLE) && !start) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule
